mod_n_chain_counter: RTL
========================

// Module: mod_n_chain_counter
// PURPOSE
//  Parametrised synchronous modulo-N multi-digit counter: DIGITS cascaded mod-MODULUS digits.
//  Default MODULUS=10 gives a BCD counter; default 2 digits count 00..99.
//  Adds up/down counting, enable, synchronous parallel load, terminal-count and wrap flags.
//  Used as the general counter/timebase primitive in digital-system designs.
// PARAMETERS
//  MODULUS  10  states per digit; legal values 2..256
//  DIGITS   2   number of cascaded digits; legal values 1..8
//  DW       $clog2(MODULUS)  digit width; derived, not overridable
// PORTS
//  clk       in   1         single clock; all state changes on the rising edge
//  clear     in   1         asynchronous, active-low reset
//  en        in   1         count enable; one step per clk while high
//  up        in   1         direction: 1 = increment, 0 = decrement
//  load      in   1         synchronous parallel load
//  load_val  in   DIGITS*DW load value; digit i is load_val[i*DW +: DW]
//  q         out  DIGITS*DW count; digit 0 is least significant
//  tc        out  1         terminal count (combinational), see below
//  wrap      out  1         registered one-cycle pulse on a full-chain wrap
//  load_err  out  1         registered one-cycle pulse when a loaded digit was >= MODULUS
// BEHAVIOUR
//  - Reset (clear=0, asynchronous): q=0, wrap=0, load_err=0. Release is synchronous to clk.
//  - Priority: load > en > hold.
//  - load=1: each digit takes load_val[i]. A digit value >= MODULUS is loaded as 0.
//    load_err=1 for the next cycle if any digit was illegal. en is ignored in a load cycle.
//  - en=1, up=1: digit 0 increments. Digit i steps only when every lower digit is MODULUS-1.
//    A digit at MODULUS-1 wraps to 0.
//  - en=1, up=0: digit 0 decrements. Digit i steps only when every lower digit is 0.
//    A digit at 0 wraps to MODULUS-1.
//  - tc = en & ~load & (up ? all digits == MODULUS-1 : all digits == 0).
//  - wrap is asserted one cycle after the clk edge on which tc=1 (the full-chain rollover).
//  - wrap and load_err deassert one cycle after assertion unless retriggered.
//  - up may change on any cycle and takes effect on the next step. There is no latency beyond 1 clk.
//  - en=0 & load=0: q holds; wrap and load_err return to 0.
//  - Reset mid-count: immediate clear; no pending wrap survives reset.
//  - Arithmetic is per-digit, at DW bits, with an explicit compare to MODULUS-1.
//    No binary overflow is relied on, which matters for non-power-of-2 moduli.
// CONFIGURATION
//  MODN_SAT_EN defined:
//    - At tc the counter holds: stays at all-max (up) or all-zero (down) instead of wrapping.
//    - wrap never asserts; tc still asserts while the count is pinned.
//    - load and direction reversal leave saturation normally.
//  MODN_SAT_EN undefined: wrap-around as described above. This is the default.
// STRUCTURE
//  - Package mod_n_pkg holds:
//    - function digit_w(MODULUS) implementing $clog2 with a minimum of 1;
//    - localparam limits MOD_MIN=2, MOD_MAX=256, DIG_MAX=8;
//    - typedef dir_t {DIR_DOWN=0, DIR_UP=1}.
//  - Sub-module mod_n_digit: one digit register with
//    - inputs: step_in, up, load, ld_val;
//    - outputs: q, at_max, at_zero, illegal.
//  - The top generates DIGITS instances and an AND-chain of at_max/at_zero for carry/borrow.
//  - The top holds the wrap/load_err registers.
//  - The top issues an elaboration-time error for out-of-range parameters.
// TESTING (MODULUS=10, DIGITS=2 unless noted)
//  1. Reset: clear=0 mid-count at q=0x37 -> q=0x00, wrap=0, load_err=0, without a clk edge.
//  2. Up count: en=1, up=1 from 0x00 for 100 clks.
//     -> q steps 00..99. tc=1 at 0x99. The next edge gives q=0x00 and wrap=1 for exactly 1 cycle.
//  3. Down count: load 0x10, then en=1, up=0.
//     -> 0x09, 0x08 ... 0x00. tc=1 at 0x00. Next q=0x99 with a wrap pulse.
//  4. Load: load_val=0x5C with en=1 -> q=0x50 and load_err=1. Load wins over en.
//     Then load_val=0x42 -> q=0x42, load_err=0.
//  5. Direction flip and enable gap: at 0x19 with up=1 -> 0x20; flip up=0 -> 0x19.
//     en=0 for 5 clks -> 0x19 held, tc=0.
//  6. MODN_SAT_EN, MODULUS=6, DIGITS=3: from 0x555 (digits 5,5,5) up.
//     -> q stays 0x555, tc=1, wrap=0. up=0 -> 0x554.

Source files
------------

// File: rtl/mod_n_pkg.sv
// -----------------------------------------------------------------------------
// mod_n_pkg
// Shared definitions for the modulo-N chain counter:
//   MOD_MIN / MOD_MAX / DIG_MAX : legal parameter limits
//   dir_t                       : count direction (DIR_DOWN=0, DIR_UP=1)
//   digit_w()                   : digit width for a modulus, ceil(log2) with a
//                                 floor of 1 bit so MODULUS=2 still gets a bit
// -----------------------------------------------------------------------------
package mod_n_pkg;

  localparam int MOD_MIN = 2;
  localparam int MOD_MAX = 256;
  localparam int DIG_MAX = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  function automatic int digit_w(input int modulus);
    return (modulus > 2) ? $clog2(modulus) : 1;
  endfunction

endpackage : mod_n_pkg

// File: rtl/mod_n_digit.sv
// -----------------------------------------------------------------------------
// mod_n_digit
// One modulo-MODULUS digit register of the chain counter. Load has priority
// over stepping; an out-of-range load value is stored as 0 and flagged.
// Ports:
//   clk      in   clock, rising edge
//   clear    in   asynchronous active-low reset
//   step_in  in   advance this digit by one in the direction given by up
//   up       in   direction (dir_t)
//   load     in   synchronous parallel load of ld_val
//   ld_val   in   DW-bit load value
//   q        out  current digit value
//   at_max   out  digit == MODULUS-1
//   at_zero  out  digit == 0
//   illegal  out  ld_val >= MODULUS (combinational, meaningful during load)
// -----------------------------------------------------------------------------
module mod_n_digit
  import mod_n_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int DW      = digit_w(MODULUS)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          step_in,
  input  dir_t          up,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_zero,
  output logic          illegal
);

  localparam logic [DW-1:0] MAX_V = DW'(MODULUS - 1);
  // One extra bit so MODULUS=256 (not representable in DW=8) compares correctly.
  localparam logic [DW:0]   MOD_V = (DW + 1)'(MODULUS);

  logic [DW-1:0] q_q, q_d;

  assign at_max  = (q_q == MAX_V);
  assign at_zero = (q_q == '0);
  assign illegal = ({1'b0, ld_val} >= MOD_V);
  assign q       = q_q;

  // Wrap points are explicit compares, never binary overflow, so non-power-of-2
  // moduli roll over at the right value.
  always_comb begin
    // NOTE: default assignment first keeps every path driven, so no latch is inferred.
    q_d = q_q;
    if (load) begin
      q_d = illegal ? '0 : ld_val;
    end else if (step_in) begin
      if (up == DIR_UP) q_d = at_max  ? '0    : q_q + DW'(1);
      else              q_d = at_zero ? MAX_V : q_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (!clear) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule : mod_n_digit

// File: rtl/mod_n_chain_counter.sv
// -----------------------------------------------------------------------------
// mod_n_chain_counter
// DIGITS cascaded modulo-MODULUS digits (default: 2-digit BCD, 00..99) with
// up/down counting, enable, synchronous parallel load, a combinational
// terminal-count flag and registered wrap / load-error pulses.
// Configuration macro:
//   MODN_SAT_EN  when defined, the chain saturates at all-max (up) or all-zero
//                (down) instead of wrapping; wrap never asserts, tc still does.
// Ports:
//   clk       in   clock, rising edge
//   clear     in   asynchronous active-low reset
//   en        in   count enable, one step per clock
//   up        in   1 = increment, 0 = decrement
//   load      in   synchronous parallel load (wins over en)
//   load_val  in   digit i at load_val[i*DW +: DW]
//   q         out  count, digit 0 least significant
//   tc        out  terminal count: en & ~load & chain at its end value
//   wrap      out  one-cycle pulse after a full-chain rollover
//   load_err  out  one-cycle pulse after a load holding an illegal digit
// -----------------------------------------------------------------------------
module mod_n_chain_counter
  import mod_n_pkg::*;
#(
  parameter  int MODULUS = 10,
  parameter  int DIGITS  = 2,
  localparam int DW      = digit_w(MODULUS)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] q,
  output logic                 tc,
  output logic                 wrap,
  output logic                 load_err
);

  if (MODULUS < MOD_MIN || MODULUS > MOD_MAX) begin : g_bad_modulus
    $error("mod_n_chain_counter: MODULUS=%0d outside %0d..%0d", MODULUS, MOD_MIN, MOD_MAX);
  end
  if (DIGITS < 1 || DIGITS > DIG_MAX) begin : g_bad_digits
    $error("mod_n_chain_counter: DIGITS=%0d outside 1..%0d", DIGITS, DIG_MAX);
  end

  dir_t              dir;
  logic [DIGITS-1:0] at_max, at_zero, illegal, hit, step;
  logic              all_hit, count_en, run;
  logic              wrap_q, wrap_d;
  logic              load_err_q, load_err_d;

  assign dir = dir_t'(up);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    mod_n_digit #(
      .MODULUS (MODULUS),
      .DW      (DW)
    ) u_digit (
      .clk     (clk),
      .clear   (clear),
      .step_in (step[i]),
      .up      (dir),
      .load    (load),
      .ld_val  (load_val[i*DW +: DW]),
      .q       (q[i*DW +: DW]),
      .at_max  (at_max[i]),
      .at_zero (at_zero[i]),
      .illegal (illegal[i])
    );
    // A digit "hits" when it is at the value that passes a carry/borrow upward.
    assign hit[i] = (dir == DIR_UP) ? at_max[i] : at_zero[i];
  end

  assign all_hit = &hit;
  assign tc      = en & ~load & all_hit;

`ifdef MODN_SAT_EN
  // Pinned at the end value: suppress the step that would roll the chain over.
  assign count_en = en & ~load & ~all_hit;
  assign wrap_d   = 1'b0;
`else
  assign count_en = en & ~load;
  assign wrap_d   = tc;
`endif

  assign load_err_d = load & (|illegal);

  // Ripple AND-chain: digit i steps only if every lower digit is at its hit value.
  always_comb begin
    run  = 1'b1;
    step = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = count_en & run;
      run     = run & hit[i];
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule : mod_n_chain_counter
